// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO debounce / LED block.
//   - led_mode encodings (mirror, toggle, blink, off)
//   - per-channel debounce FSM state encoding
package gpio_pkg;

  localparam logic [1:0] LedModeMirror = 2'b00;
  localparam logic [1:0] LedModeToggle = 2'b01;
  localparam logic [1:0] LedModeBlink  = 2'b10;
  localparam logic [1:0] LedModeOff    = 2'b11;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StWaitHi   = 2'b01,
    StStableHi = 2'b10,
    StWaitLo   = 2'b11
  } db_state_e;

endpackage

// File: rtl/gpio_debounce_ch.sv
// Single-channel switch conditioner: 2-flop synchronizer, debounce FSM with
// stability counter, and registered rise/fall pulses.
// Ports:
//   clk_i   - clock
//   rst_ni  - synchronous active-low reset
//   raw_i   - raw asynchronous switch level
//   db_o    - debounced level
//   rise_o  - one-cycle pulse in the first cycle db_o reads 1
//   fall_o  - one-cycle pulse in the first cycle db_o reads 0
module gpio_debounce_ch
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  // The count reaches DEBOUNCE_CYCLES on the edge that commits the change.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            sample;

  assign sample = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (sample) begin
          state_d = StWaitHi;
          cnt_d   = CntW'(1);
        end
      end
      StWaitHi: begin
        if (!sample) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHi;
          cnt_d   = '0;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStableHi: begin
        if (!sample) begin
          state_d = StWaitLo;
          cnt_d   = CntW'(1);
        end
      end
      StWaitLo: begin
        if (sample) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLo;
          cnt_d   = '0;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= StStableLo;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_debounce_led.sv
// Multi-channel switch debouncer driving LEDs in one of four modes
// (mirror, toggle-on-press, blink, off).
// Ports:
//   SYSTEMCLOCK         - clock, all state on rising edge
//   PUSH_BUTTON_RESET_N - synchronous active-low reset
//   gpio_switch         - raw bouncing switch inputs
//   led_mode            - LED mode select (synchronous)
//   gpio_led            - registered LED drive
//   sw_db               - debounced switch levels
//   sw_rise / sw_fall   - one-cycle edge pulses of sw_db
// Build option: define GPIO_BLINK_EN to include the blink counter; without it
// blink mode behaves like mirror mode.
module gpio_debounce_led
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic              SYSTEMCLOCK,
  input  logic              PUSH_BUTTON_RESET_N,
  input  logic [NUM_CH-1:0] gpio_switch,
  input  logic [1:0]        led_mode,
  output logic [NUM_CH-1:0] gpio_led,
  output logic [NUM_CH-1:0] sw_db,
  output logic [NUM_CH-1:0] sw_rise,
  output logic [NUM_CH-1:0] sw_fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i (SYSTEMCLOCK),
      .rst_ni(PUSH_BUTTON_RESET_N),
      .raw_i (gpio_switch[i]),
      .db_o  (sw_db[i]),
      .rise_o(sw_rise[i]),
      .fall_o(sw_fall[i])
    );
  end

  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [NUM_CH-1:0] led_q, led_d;

`ifdef GPIO_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_DIV);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BlinkW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge SYSTEMCLOCK) begin
    if (!PUSH_BUTTON_RESET_N) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  always_comb begin
    // Toggle state is frozen outside toggle mode so it survives mode changes.
    toggle_d = toggle_q;
    if (led_mode == LedModeToggle) begin
      toggle_d = toggle_q ^ sw_rise;
    end

    led_d = '0;
    unique case (led_mode)
      LedModeMirror: led_d = sw_db;
      LedModeToggle: led_d = toggle_q;
`ifdef GPIO_BLINK_EN
      LedModeBlink:  led_d = sw_db & {NUM_CH{blink_phase_q}};
`else
      LedModeBlink:  led_d = sw_db;
`endif
      LedModeOff:    led_d = '0;
      default:       led_d = '0;
    endcase
  end

  always_ff @(posedge SYSTEMCLOCK) begin
    if (!PUSH_BUTTON_RESET_N) begin
      toggle_q <= '0;
      led_q    <= '0;
    end else begin
      toggle_q <= toggle_d;
      led_q    <= led_d;
    end
  end

  assign gpio_led = led_q;

endmodule

// File: doc/gpio_debounce_led.md
GPIO_DEBOUNCE_LED -- requirements
Module: gpio_debounce_led

Interface
REQ-001 Parameter NUM_CH, default 4: number of switch/LED channels, range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000: consecutive stable synchronized samples needed to accept a switch change, range 2..2^20.
REQ-003 Parameter BLINK_DIV, default 25000000: SYSTEMCLOCK cycles per blink half-period, range 2..2^28.
REQ-004 Port SYSTEMCLOCK, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port PUSH_BUTTON_RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port gpio_switch, input, NUM_CH bits: raw, asynchronous, bouncing switch levels.
REQ-007 Port led_mode, input, 2 bits: LED mode select, already synchronous to SYSTEMCLOCK.
REQ-008 Port gpio_led, output, NUM_CH bits: registered LED drive.
REQ-009 Port sw_db, output, NUM_CH bits: debounced switch levels.
REQ-010 Port sw_rise, output, NUM_CH bits: one-cycle pulse per channel when sw_db goes 0->1.
REQ-011 Port sw_fall, output, NUM_CH bits: one-cycle pulse per channel when sw_db goes 1->0.

Function
REQ-012 Each gpio_switch bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run an independent FSM with states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-014 In STABLE_x, a synchronized sample that differs from sw_db SHALL move the FSM to WAIT_x with the counter set to 1.
REQ-015 In WAIT_x, a sample that still differs SHALL increment the counter; when the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter the opposite STABLE state, toggle sw_db, and clear the counter.
REQ-016 In WAIT_x, a sample equal to sw_db SHALL return the FSM to STABLE_x and clear the counter, so sw_db does not change.
REQ-017 From a raw change held stable, sw_db SHALL change exactly DEBOUNCE_CYCLES+2 rising edges later.
REQ-018 sw_rise and sw_fall SHALL be high only in the cycle in which sw_db first shows its new value.
REQ-019 Mode 00 (MIRROR) SHALL set gpio_led = sw_db, one cycle later.
REQ-020 Mode 01 (TOGGLE) SHALL invert a channel's toggle register on its sw_rise, and gpio_led SHALL follow the toggle register one cycle later.
REQ-021 The toggle register SHALL update only in TOGGLE mode and SHALL hold its value across mode changes.
REQ-022 Mode 10 (BLINK) SHALL set gpio_led = sw_db AND blink_phase, one cycle later; blink_phase SHALL toggle whenever the blink counter wraps from BLINK_DIV-1 to 0.
REQ-023 Mode 11 (OFF) SHALL drive gpio_led to all zeros.
REQ-024 A led_mode change SHALL take effect on gpio_led one cycle later, with no glitch or extra toggle.
REQ-025 Simultaneous events on different channels SHALL be handled independently, and every channel's latency SHALL be identical.

Reset
REQ-026 While PUSH_BUTTON_RESET_N is sampled low: gpio_led, sw_db, sw_rise, sw_fall, the synchronizers, the toggle registers, blink_phase and all counters SHALL be 0, and every FSM SHALL be in STABLE_LO.
REQ-027 A reset asserted during WAIT_x SHALL abandon the pending change.
REQ-028 After release, a switch already held high SHALL produce sw_db=1 and one sw_rise pulse DEBOUNCE_CYCLES+2 cycles later.

Configuration
REQ-029 With GPIO_BLINK_EN defined, mode 10 SHALL behave as in REQ-022.
REQ-030 Without GPIO_BLINK_EN, the blink counter and blink_phase SHALL NOT be synthesized, and mode 10 SHALL behave exactly as mode 00.

Structure
REQ-031 Shared package gpio_pkg SHALL hold the led_mode encoding constants and the debounce FSM state encoding.
REQ-032 Per-channel synchronizer, FSM, counter and edge detection SHALL be a sub-module gpio_debounce_ch, instantiated NUM_CH times in a generate loop.
REQ-033 The blink counter and the toggle registers SHALL be in the top level and shared across channels.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=8, BLINK_DIV=16, GPIO_BLINK_EN defined)
REQ-034 Mode 00, switch 4'h0->4'h1 held -> sw_db=4'h1 and sw_rise=4'h1 for one cycle exactly 10 edges after the change; gpio_led=4'h1 one cycle after that.
REQ-035 Bit0 pulsed high for 5 cycles then low -> sw_db stays 4'h0, with no sw_rise or sw_fall.
REQ-036 Mode 01, bit1 pressed and released twice (each level held 20 cycles) -> gpio_led[1] goes 1 then 0; switch to mode 00 and back to 01 -> gpio_led[1] is still 0.
REQ-037 Mode 10, switch 4'hF held -> gpio_led alternates between 4'hF and 4'h0 every 16 cycles; rebuilt without GPIO_BLINK_EN -> gpio_led is a steady 4'hF.
REQ-038 Reset asserted 4 cycles into a debounce of 4'h8, then released while the switch is held -> all outputs 0 during reset; sw_db=4'h8 10 edges after release, with exactly one sw_rise[3].
REQ-039 Channels 0 and 3 change in the same cycle -> sw_rise=4'h9 in a single cycle.
